// File: rtl/pe_pkg.sv
// Shared types and constants for the sparse row-convolution processing element.
package pe_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned ACC_WIDTH_DEF   = 24;
  localparam int unsigned IF_WIDTH        = 16;
  localparam int unsigned KERNEL_WIDTH    = 3;
  localparam int unsigned KERNEL_SIZE     = KERNEL_WIDTH * KERNEL_WIDTH;
  localparam int unsigned ACT_INDEX_WIDTH = $clog2(IF_WIDTH);
  localparam int unsigned OUT_WIDTH       = IF_WIDTH - KERNEL_WIDTH + 1;
  localparam int unsigned COL_W           = $clog2(KERNEL_WIDTH);

  // Saturation limits for the default accumulator width
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    TAP      = 2'd2,
    DRAIN    = 2'd3
  } pe_state_e;

  // Flat kernel slot of weight (row, col); slot k lives at bits [8k+7:8k]
  function automatic int unsigned weight_idx(input int unsigned row, input int unsigned col);
    return row * KERNEL_WIDTH + col;
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Signed multiply of activation and weight added into a saturating accumulator.
module pe_mac_sat #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic signed [DATA_WIDTH-1:0] act_i,
  input  logic signed [DATA_WIDTH-1:0] wgt_i,
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned SUM_W  = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;

  // One guard bit catches overflow; clamp toward the sign of the true sum
  always_comb begin
    prod = act_i * wgt_i;
    sum  = SUM_W'(acc_i) + SUM_W'(prod);
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      acc_o = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_o = sum[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pe_row_accumulator.sv
// Zero-skipping 1-D row convolution into a partial-sum row buffer with a valid/ready drain.
module pe_row_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] parallel_out,
  input  logic                              en,
  input  logic [DATA_WIDTH-1:0]             serial_out,
  input  logic [ACT_INDEX_WIDTH-1:0]        act_index,
  input  logic [ACT_INDEX_WIDTH-1:0]        row_index,
  input  logic [ACT_INDEX_WIDTH:0]          row_val_num,
  input  logic                              zero_flag,
  output logic                              row_finish_done,
  output logic                              row_cal_done,
  output logic [ACC_WIDTH-1:0]              psum_data,
  output logic [ACT_INDEX_WIDTH-1:0]        psum_index,
  output logic                              psum_valid,
  input  logic                              psum_ready,
  output logic                              busy
);

  localparam int unsigned CNT_W = ACT_INDEX_WIDTH + 1;

  pe_state_e                                     state_q;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]        kernel_q;
  logic signed [ACC_WIDTH-1:0]                   acc_q [OUT_WIDTH];
  logic signed [ACC_WIDTH-1:0]                   acc_d [OUT_WIDTH];
  logic signed [DATA_WIDTH-1:0]                  act_q;
  logic [ACT_INDEX_WIDTH-1:0]                    act_idx_q;
  logic [ACT_INDEX_WIDTH-1:0]                    row_idx_q;
  logic [CNT_W-1:0]                              row_num_q;
  logic [CNT_W-1:0]                              act_cnt_q;
  logic                                          row_open_q;
  logic [COL_W-1:0]                              tap_col_q;
  logic                                          tap_hit_q;
  logic                                          row_finish_q;
  logic                                          row_cal_q;
  logic                                          psum_valid_q;
  logic [ACT_INDEX_WIDTH-1:0]                    psum_idx_q;
  logic                                          busy_q;

  logic [ACT_INDEX_WIDTH-1:0]   sel_row;
  logic [KERNEL_WIDTH-1:0]      mask;
  logic [COL_W:0]               search_from;
  logic                         next_hit;
  logic [COL_W-1:0]             next_col;
  logic [ACT_INDEX_WIDTH-1:0]   tap_ofs;
  logic                         ofs_ok;
  logic signed [DATA_WIDTH-1:0] w_cur;
  logic signed [ACC_WIDTH-1:0]  acc_rd;
  logic signed [ACC_WIDTH-1:0]  acc_sum;

  // Kernel weight lookup; rows beyond the kernel read as zero
  function automatic logic signed [DATA_WIDTH-1:0] weight_at(
    input logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kern,
    input logic [ACT_INDEX_WIDTH-1:0]             row,
    input logic [COL_W-1:0]                       col
  );
    weight_at = '0;
    for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
      if (k == weight_idx(32'(row), 32'(col))) weight_at = $signed(kern[k]);
    end
  endfunction

  // Next nonzero tap: first column on acceptance, the following one while tapping
  always_comb begin
    sel_row     = (state_q == WAIT_ROW && !row_open_q) ? row_index : row_idx_q;
    search_from = (state_q == TAP) ? ((COL_W+1)'(tap_col_q) + (COL_W+1)'(1)) : '0;
    mask        = '0;
    next_hit    = 1'b0;
    next_col    = '0;
    for (int c = 0; c < KERNEL_WIDTH; c++) begin
      mask[c] = (weight_at(kernel_q, sel_row, COL_W'(c)) != '0);
    end
    for (int c = KERNEL_WIDTH - 1; c >= 0; c--) begin
      if (mask[c] && ((COL_W+1)'(c) >= search_from)) begin
        next_hit = 1'b1;
        next_col = COL_W'(c);
      end
    end
  end

  // Output column hit by the current tap and its current partial sum
  always_comb begin
    tap_ofs = act_idx_q - ACT_INDEX_WIDTH'(tap_col_q);
    ofs_ok  = (ACT_INDEX_WIDTH'(tap_col_q) <= act_idx_q) &&
              (tap_ofs < ACT_INDEX_WIDTH'(OUT_WIDTH));
    w_cur   = weight_at(kernel_q, row_idx_q, tap_col_q);
    acc_rd  = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      if (tap_ofs == ACT_INDEX_WIDTH'(i)) acc_rd = acc_q[i];
    end
  end

  pe_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .act_i (act_q),
    .wgt_i (w_cur),
    .acc_i (acc_rd),
    .acc_o (acc_sum)
  );

  // Accumulator next state: clear on start, update on tap, shift down on drain beat
  always_comb begin
    for (int unsigned i = 0; i < OUT_WIDTH; i++) acc_d[i] = acc_q[i];
    if (state_q == IDLE && start) begin
      for (int unsigned i = 0; i < OUT_WIDTH; i++) acc_d[i] = '0;
    end else if (state_q == TAP && tap_hit_q && ofs_ok) begin
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
        if (tap_ofs == ACT_INDEX_WIDTH'(i)) acc_d[i] = acc_sum;
      end
    end else if (state_q == DRAIN && psum_ready) begin
      for (int unsigned i = 0; i + 1 < OUT_WIDTH; i++) acc_d[i] = acc_q[i+1];
      acc_d[OUT_WIDTH-1] = '0;
    end
  end

  // Control FSM, row bookkeeping and registered handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      kernel_q     <= '0;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) acc_q[i] <= '0;
      act_q        <= '0;
      act_idx_q    <= '0;
      row_idx_q    <= '0;
      row_num_q    <= '0;
      act_cnt_q    <= '0;
      row_open_q   <= 1'b0;
      tap_col_q    <= '0;
      tap_hit_q    <= 1'b0;
      row_finish_q <= 1'b0;
      row_cal_q    <= 1'b0;
      psum_valid_q <= 1'b0;
      psum_idx_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < OUT_WIDTH; i++) acc_q[i] <= acc_d[i];
      row_finish_q <= 1'b0;
      row_cal_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            kernel_q   <= parallel_out;
            row_open_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          if (en) begin
            if (zero_flag || (!row_open_q && row_val_num == '0)) begin
              row_cal_q  <= 1'b1;
              row_open_q <= 1'b0;
              if (row_index == ACT_INDEX_WIDTH'(KERNEL_WIDTH-1)) begin
                state_q      <= DRAIN;
                psum_valid_q <= 1'b1;
                psum_idx_q   <= '0;
              end
            end else begin
              act_q     <= $signed(serial_out);
              act_idx_q <= act_index;
              if (!row_open_q) begin
                row_open_q <= 1'b1;
                row_idx_q  <= row_index;
                row_num_q  <= row_val_num;
                act_cnt_q  <= '0;
              end
              tap_hit_q <= next_hit;
              tap_col_q <= next_col;
              state_q   <= TAP;
            end
          end
        end
        TAP: begin
          if (!tap_hit_q || !next_hit) begin
            row_finish_q <= 1'b1;
            act_cnt_q    <= act_cnt_q + CNT_W'(1);
            if (act_cnt_q + CNT_W'(1) == row_num_q) begin
              row_cal_q  <= 1'b1;
              row_open_q <= 1'b0;
              if (row_idx_q == ACT_INDEX_WIDTH'(KERNEL_WIDTH-1)) begin
                state_q      <= DRAIN;
                psum_valid_q <= 1'b1;
                psum_idx_q   <= '0;
              end else begin
                state_q <= WAIT_ROW;
              end
            end else begin
              state_q <= WAIT_ROW;
            end
          end else begin
            tap_col_q <= next_col;
          end
        end
        DRAIN: begin
          if (psum_ready) begin
            if (psum_idx_q == ACT_INDEX_WIDTH'(OUT_WIDTH-1)) begin
              psum_valid_q <= 1'b0;
              psum_idx_q   <= '0;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              psum_idx_q <= psum_idx_q + ACT_INDEX_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_finish_done = row_finish_q;
  assign row_cal_done    = row_cal_q;
  assign psum_data       = acc_q[0];
  assign psum_index      = psum_idx_q;
  assign psum_valid      = psum_valid_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pe_row_accumulator.sv
// Directed bench for pe_row_accumulator: taps, edges, zero skip, empty rows, drain, saturation, reset.
module tb_pe_row_accumulator;
  import pe_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [DW*KERNEL_SIZE-1:0]   parallel_out;
  logic                        en;
  logic [DW-1:0]               serial_out;
  logic [ACT_INDEX_WIDTH-1:0]  act_index;
  logic [ACT_INDEX_WIDTH-1:0]  row_index;
  logic [ACT_INDEX_WIDTH:0]    row_val_num;
  logic                        zero_flag;
  logic                        row_finish_done;
  logic                        row_cal_done;
  logic [AW-1:0]               psum_data;
  logic [ACT_INDEX_WIDTH-1:0]  psum_index;
  logic                        psum_valid;
  logic                        psum_ready;
  logic                        busy;

  int n_pass  = 0;
  int n_total = 0;
  int exp_acc [OUT_WIDTH];

  always #5 clk = ~clk;

  pe_row_accumulator #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .parallel_out    (parallel_out),
    .en              (en),
    .serial_out      (serial_out),
    .act_index       (act_index),
    .row_index       (row_index),
    .row_val_num     (row_val_num),
    .zero_flag       (zero_flag),
    .row_finish_done (row_finish_done),
    .row_cal_done    (row_cal_done),
    .psum_data       (psum_data),
    .psum_index      (psum_index),
    .psum_valid      (psum_valid),
    .psum_ready      (psum_ready),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Row-major kernel: aN = row 0, bN = row 1, cN = row 2; weight 0 in the low byte
  function automatic logic [DW*KERNEL_SIZE-1:0] kern(
    input logic [DW-1:0] a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return {c2, c1, c0, b2, b1, b0, a2, a1, a0};
  endfunction

  task automatic do_start(input string tag, input logic [DW*KERNEL_SIZE-1:0] k);
    parallel_out = k;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    parallel_out = '0;
    check({tag, "_busy"}, busy, 1);
  endtask

  // Present one activation, then measure cycles until row_finish_done
  task automatic send_act(input string tag, input logic [DW-1:0] val, input logic [3:0] idx,
                          input logic [3:0] row, input logic [4:0] num,
                          input int exp_lat, input logic exp_cal);
    int   lat;
    logic cal;
    lat         = 0;
    cal         = 1'b0;
    serial_out  = val;
    act_index   = idx;
    row_index   = row;
    row_val_num = num;
    zero_flag   = 1'b0;
    en          = 1'b1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) en = 1'b0;
      if (row_finish_done) begin
        lat = k;
        cal = row_cal_done;
      end
    end
    check($sformatf("%s_lat", tag), lat, exp_lat);
    check($sformatf("%s_cal", tag), cal, exp_cal);
  endtask

  // Empty row descriptor, flagged either by zero_flag or by row_val_num == 0
  task automatic empty_row(input string tag, input logic [3:0] row, input logic zf);
    en          = 1'b1;
    zero_flag   = zf;
    row_val_num = '0;
    row_index   = row;
    @(negedge clk);
    en        = 1'b0;
    zero_flag = 1'b0;
    check({tag, "_cal"}, row_cal_done, 1);
    check({tag, "_fin"}, row_finish_done, 0);
  endtask

  // Drain all beats against exp_acc, optionally stalling on beat 0 first
  task automatic drain(input string tag, input int stall);
    check({tag, "_valid"}, psum_valid, 1);
    psum_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check($sformatf("%s_stall%0d_idx", tag, s), psum_index, 0);
      check($sformatf("%s_stall%0d_data", tag, s), $signed(psum_data), exp_acc[0]);
    end
    psum_ready = 1'b1;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      check($sformatf("%s_b%0d_valid", tag, i), psum_valid, 1);
      check($sformatf("%s_b%0d_idx", tag, i), psum_index, i);
      check($sformatf("%s_b%0d_data", tag, i), $signed(psum_data), exp_acc[i]);
      @(negedge clk);
    end
    psum_ready = 1'b0;
    check({tag, "_end_valid"}, psum_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic stray;
    reset = 1'b1; start = 1'b0; en = 1'b0; zero_flag = 1'b0; psum_ready = 1'b0;
    parallel_out = '0; serial_out = '0; act_index = '0; row_index = '0; row_val_num = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_fin", row_finish_done, 0);
    check("rst_cal", row_cal_done, 0);
    check("rst_valid", psum_valid, 0);
    check("rst_idx", psum_index, 0);
    check("rst_data", $signed(psum_data), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // All-ones kernel: full taps, both edge columns, empty rows
    do_start("a_start", kern(1, 1, 1, 1, 1, 1, 1, 1, 1));
    send_act("a_r0", 8'd5, 4'd4, 4'd0, 5'd1, 4, 1'b1);
    empty_row("a_e1", 4'd1, 1'b1);
    check("a_e1_busy", busy, 1);
    check("a_e1_valid", psum_valid, 0);
    send_act("a_r1c0", 8'd2, 4'd0, 4'd1, 5'd2, 4, 1'b0);
    send_act("a_r1c15", 8'd3, 4'd15, 4'd1, 5'd2, 4, 1'b1);
    empty_row("a_e2", 4'd2, 1'b1);
    exp_acc = '{2, 0, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    drain("a_dr", 2);

    // Sparse kernel: zero skip, all-zero row, row_val_num=0, ignored start
    do_start("b_start", kern(0, 0, 0, 0, 4, 0, 8'hFF, 0, 2));
    empty_row("b_num0", 4'd0, 1'b0);
    send_act("b_skip", 8'd6, 4'd7, 4'd1, 5'd1, 2, 1'b1);
    send_act("b_zrow", 8'd9, 4'd3, 4'd0, 5'd1, 2, 1'b1);
    parallel_out = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b_start_ign_busy", busy, 1);
    check("b_start_ign_valid", psum_valid, 0);
    send_act("b_r2a", 8'hFD, 4'd10, 4'd2, 5'd2, 3, 1'b0);
    send_act("b_r2b", 8'd7, 4'd2, 4'd2, 5'd2, 3, 1'b1);
    exp_acc = '{14, 0, -7, 0, 0, 0, 24, 0, -6, 0, 3, 0, 0, 0};
    drain("b_dr", 0);

    // Positive saturation
    do_start("c_start", kern(127, 127, 127, 127, 127, 127, 127, 127, 127));
    send_act("c_p1", 8'd127, 4'd5, 4'd0, 5'd3, 4, 1'b0);
    send_act("c_p2", 8'd127, 4'd5, 4'd0, 5'd3, 4, 1'b0);
    send_act("c_p3", 8'd127, 4'd5, 4'd0, 5'd3, 4, 1'b1);
    empty_row("c_e2", 4'd2, 1'b1);
    exp_acc = '{0, 0, 0, 32767, 32767, 32767, 0, 0, 0, 0, 0, 0, 0, 0};
    drain("c_dr", 0);

    // Negative saturation
    do_start("d_start", kern(127, 127, 127, 127, 127, 127, 127, 127, 127));
    send_act("d_n1", 8'h80, 4'd5, 4'd0, 5'd3, 4, 1'b0);
    send_act("d_n2", 8'h80, 4'd5, 4'd0, 5'd3, 4, 1'b0);
    send_act("d_n3", 8'h80, 4'd5, 4'd0, 5'd3, 4, 1'b1);
    empty_row("d_e2", 4'd2, 1'b1);
    exp_acc = '{0, 0, 0, -32768, -32768, -32768, 0, 0, 0, 0, 0, 0, 0, 0};
    drain("d_dr", 0);

    // Reset in the middle of a tap sequence
    do_start("e_start", kern(1, 1, 1, 1, 1, 1, 1, 1, 1));
    serial_out = 8'd5; act_index = 4'd0; row_index = 4'd2; row_val_num = 5'd1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("e_pre_data", $signed(psum_data), 5);
    check("e_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("e_rst_busy", busy, 0);
    check("e_rst_fin", row_finish_done, 0);
    check("e_rst_cal", row_cal_done, 0);
    check("e_rst_valid", psum_valid, 0);
    check("e_rst_data", $signed(psum_data), 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stray = stray | row_finish_done | row_cal_done | psum_valid | busy;
    end
    check("e_no_stray", stray, 0);
    en = 1'b1; zero_flag = 1'b1; row_index = 4'd2;
    @(negedge clk);
    en = 1'b0; zero_flag = 1'b0;
    check("e_idle_en_cal", row_cal_done, 0);
    check("e_idle_en_busy", busy, 0);
    do_start("e_restart", kern(1, 1, 1, 1, 1, 1, 1, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
